mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage plus MEM/WB pipeline register; sits directly upstream of the write-back mux and feeds it memout, aluout and the 2-bit WB control (WB[1]=MemtoReg, WB[0]=RegWrite).
- Drives the data-memory request/acknowledge handshake and produces byte enables for stores.
- Sign/zero-extends load data.
- Stalls the front of the pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT_CYC, 16, maximum cycles dm_req may stay high without dm_ack before the access is aborted (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_wb  in  2  WB control {MemtoReg, RegWrite}
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  RV32I load/store funct3
- ex_aluout  in  32  ALU result / effective address
- ex_rs2data  in  32  store data
- ex_rd  in  5  destination register
- mem_stall  out  1  hold IF/ID/EX and EX/MEM this cycle
- dm_req  out  1  data-memory request
- dm_web  out  4  byte write enables (0000 = read)
- dm_addr  out  32  word address {ex_aluout[31:2],2'b00}
- dm_wdata  out  32  lane-aligned store data
- dm_rdata  in  32  read data, valid when dm_ack=1
- dm_ack  in  1  access complete this cycle
- wb_valid  out  1  MEM/WB valid
- wb_ctrl  out  2  MEM/WB WB control
- wb_memout  out  32  extended load data
- wb_aluout  out  32  registered ex_aluout
- wb_rd  out  5  registered ex_rd
- err_misalign  out  1  sticky: misaligned access seen
- err_timeout  out  1  sticky: access aborted by timeout

Behaviour:
- Reset (async, rst=1): state=IDLE, timeout counter=0, wb_valid=0, wb_ctrl=00, wb_memout=0, wb_aluout=0, wb_rd=0, err_*=0. dm_req and mem_stall are 0 while rst=1.
- mem_op = ex_valid & (ex_mem_read | ex_mem_write).
- misaligned = mem_op & (halfword with addr[0]=1, or word with addr[1:0]!=0).
- Misaligned op:
  - no dm_req is issued and no stall occurs.
  - MEM/WB loads next edge with wb_valid=1 and wb_ctrl[0] forced 0.
  - err_misalign sets.
- FSM states:
  - IDLE: aligned mem_op drives dm_req=1 combinationally in the same cycle. If dm_ack=1 in that cycle (zero-wait), the access completes and the state stays IDLE. Otherwise go to WAIT.
  - WAIT: dm_req=1 with dm_addr, dm_web and dm_wdata stable. On dm_ack, complete and return to IDLE. If the counter reaches TIMEOUT_CYC-1 without an ack, abort: dm_req drops next cycle, err_timeout sets, MEM/WB loads with wb_ctrl[0]=0, return to IDLE.
- Timeout counter: clears in IDLE and increments each WAIT cycle.
- mem_stall = aligned mem_op & ~dm_ack & ~abort. Upstream holds the ex_* inputs stable while mem_stall=1.
- MEM/WB register loads on every edge where mem_stall=0:
  - wb_valid <= ex_valid; wb_ctrl <= ex_wb (with RegWrite suppression as above); wb_aluout <= ex_aluout; wb_rd <= ex_rd.
  - wb_memout <= extended dm_rdata on load completion, else 0.
  - Latency: non-memory op 1 cycle; memory op = ack cycle + 1.
- While mem_stall=1, MEM/WB loads a bubble: wb_valid=0, wb_ctrl=00. WB must never write twice.
- Store lanes:
  - SB: dm_web = one-hot at addr[1:0]; dm_wdata = byte replicated x4.
  - SH: dm_web = 0011 or 1100 by addr[1]; dm_wdata = half replicated x2.
  - SW: dm_web = 1111.
  - Loads: dm_web = 0000.
- Load extension: the byte/half is selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Undefined funct3 is treated as LW.
- Simultaneous dm_ack and timeout terminal count: ack wins and the access completes normally.
- Reset asserted mid-WAIT: dm_req drops immediately and the in-flight access is discarded.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - state enum mem_state_e {IDLE, WAIT}.
  - WB control bit indices WB_MEMTOREG=1, WB_REGWRITE=0.
- One combinational sub-module load_extend (funct3, addr[1:0], rdata -> 32-bit result) is natural.
- Store-lane logic stays inline.

Test Plan:
- ADD-type op, ex_aluout=0x1234, ex_rd=5, ex_wb=01, no dm_req -> next edge wb_valid=1, wb_aluout=0x1234, wb_rd=5, mem_stall never 1.
- LB at 0x103, dm_rdata=0x80FFFFFF, dm_ack after 3 cycles -> mem_stall=1 for 3 cycles, bubbles in WB, then wb_memout=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH at 0x202, rs2=0x0000BEEF, zero-wait ack -> dm_web=1100, dm_wdata=0xBEEFBEEF, dm_addr=0x200, no stall.
- SW at 0x301 -> dm_req=0, err_misalign=1, wb_ctrl[0]=0, no stall.
- Load with dm_ack never asserted, TIMEOUT_CYC=16 -> dm_req high 16 cycles then 0, err_timeout=1, wb_ctrl[0]=0, mem_stall released.
- rst pulse during WAIT -> dm_req=0 and all wb_* outputs=0 immediately; after release, a new LW completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 codes,
// FSM state type and WB control bit positions.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWRITE = 0;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension.
// funct3 + addr[1:0] select lane of rdata -> result.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    unique case (funct3)
      F3_LB:   result = {{24{b[7]}}, b};
      F3_LH:   result = {{16{h[15]}}, h};
      F3_LBU:  result = {24'd0, b};
      F3_LHU:  result = {16'd0, h};
      F3_LW:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage + MEM/WB register: dmem handshake, store
// lanes, load extension, stall and timeout abort.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [1:0]  ex_wb,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_rs2data,
  input  logic [4:0]  ex_rd,
  output logic        mem_stall,
  output logic        dm_req,
  output logic [3:0]  dm_web,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        wb_valid,
  output logic [1:0]  wb_ctrl,
  output logic [31:0] wb_memout,
  output logic [31:0] wb_aluout,
  output logic [4:0]  wb_rd,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  mem_state_e    state, nstate;
  logic [CW-1:0] cnt, cnt_n;

  logic        mem_op, is_byte, is_half, is_word;
  logic        misaligned, aligned, abort, ld_done;
  logic [3:0]  web_st;
  logic [1:0]  ctrl_n;
  logic [31:0] ext;
  logic [1:0]  a;

  assign a       = ex_aluout[1:0];
  assign mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
  assign is_byte = ex_funct3[1:0] == 2'b00;
  assign is_half = ex_funct3[1:0] == 2'b01;
  assign is_word = ~is_byte & ~is_half;

  assign misaligned = mem_op &
    ((is_half & a[0]) | (is_word & (|a)));
  assign aligned = mem_op & ~misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= cnt_n;
    end
  end

  // The IDLE cycle that raises dm_req counts as the
  // first request cycle, so WAIT starts at count 1.
  always_comb begin
    nstate = state;
    cnt_n  = cnt;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (aligned & ~dm_ack) begin
          nstate = WAIT;
          cnt_n  = CW'(1);
        end
      end
      WAIT: begin
        cnt_n = cnt + CW'(1);
        if (~aligned | dm_ack | abort) begin
          nstate = IDLE;
          cnt_n  = '0;
        end
      end
      default: begin
        nstate = IDLE;
        cnt_n  = '0;
      end
    endcase
  end

  // ack beats the terminal count
  always_comb begin
    abort = (state == WAIT) & aligned & ~dm_ack &
            (cnt == LAST);
    dm_req    = ~rst & aligned;
    mem_stall = ~rst & aligned & ~dm_ack & ~abort;
  end

  always_comb begin
    web_st   = 4'b1111;
    dm_wdata = ex_rs2data;
    unique case (ex_funct3[1:0])
      F3_SB[1:0]: begin
        web_st   = 4'b0001 << a;
        dm_wdata = {4{ex_rs2data[7:0]}};
      end
      F3_SH[1:0]: begin
        web_st   = a[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{ex_rs2data[15:0]}};
      end
      F3_SW[1:0]: web_st = 4'b1111;
      default:    web_st = 4'b1111;
    endcase
  end

  assign dm_web  = (dm_req & ex_mem_write) ? web_st : 4'b0000;
  assign dm_addr = {ex_aluout[31:2], 2'b00};

  load_extend u_ext (
    .funct3 (ex_funct3),
    .addr   (a),
    .rdata  (dm_rdata),
    .result (ext)
  );

  assign ld_done = aligned & ex_mem_read &
                   ~ex_mem_write & dm_ack;

  always_comb begin
    ctrl_n = 2'b00;
    ctrl_n[WB_MEMTOREG] = ex_wb[WB_MEMTOREG];
    ctrl_n[WB_REGWRITE] = ex_wb[WB_REGWRITE] &
                          ~(misaligned | abort);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_ctrl      <= 2'b00;
      wb_memout    <= '0;
      wb_aluout    <= '0;
      wb_rd        <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_misalign <= err_misalign | misaligned;
      err_timeout  <= err_timeout | abort;
      if (mem_stall) begin
        wb_valid <= 1'b0;
        wb_ctrl  <= 2'b00;
      end else begin
        wb_valid  <= ex_valid;
        wb_ctrl   <= ctrl_n;
        wb_aluout <= ex_aluout;
        wb_rd     <= ex_rd;
        wb_memout <= ld_done ? ext : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan steps
// plus random ops against a behavioural reference model.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [1:0]  ex_wb;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_aluout;
  logic [31:0] ex_rs2data;
  logic [4:0]  ex_rd;
  logic        mem_stall;
  logic        dm_req;
  logic [3:0]  dm_web;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        wb_valid;
  logic [1:0]  wb_ctrl;
  logic [31:0] wb_memout;
  logic [31:0] wb_aluout;
  logic [4:0]  wb_rd;
  logic        err_misalign;
  logic        err_timeout;

  mem_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_wb        (ex_wb),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_funct3    (ex_funct3),
    .ex_aluout    (ex_aluout),
    .ex_rs2data   (ex_rs2data),
    .ex_rd        (ex_rd),
    .mem_stall    (mem_stall),
    .dm_req       (dm_req),
    .dm_web       (dm_web),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .dm_ack       (dm_ack),
    .wb_valid     (wb_valid),
    .wb_ctrl      (wb_ctrl),
    .wb_memout    (wb_memout),
    .wb_aluout    (wb_aluout),
    .wb_rd        (wb_rd),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_mis  = 1'b0;
  bit exp_to   = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(
      input logic [2:0] f3, input logic [31:0] addr,
      input logic [31:0] rd);
    logic [31:0] v;
    logic signed [7:0] sb;
    logic signed [15:0] sh;
    int i;
    v  = rd >> (8 * (addr % 4));
    sb = v[7:0];
    sh = v[15:0];
    case (f3)
      3'd0: begin i = sb; return i; end
      3'd1: begin i = sh; return i; end
      3'd4: return v & 32'hFF;
      3'd5: return v & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_web(
      input logic [2:0] f3, input logic [31:0] addr);
    int s, o;
    s = size_of(f3);
    o = addr % 4;
    if (s == 1) return 4'(1 << o);
    if (s == 2) return 4'(3 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(
      input logic [2:0] f3, input logic [31:0] d);
    int s;
    s = size_of(f3);
    if (s == 1) return (d & 32'hFF) * 32'h01010101;
    if (s == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge. ackd = cycles of wait
  // before dm_ack (-1 = never).
  task automatic do_op(
      input bit v, input logic [1:0] wb,
      input bit re, input bit we, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] rs2,
      input logic [4:0] rd, input logic [31:0] rdat,
      input int ackd);
    bit memop, mis, al, ack, abrt, stl, done;
    int k;
    ex_valid     = v;
    ex_wb        = wb;
    ex_mem_read  = re;
    ex_mem_write = we;
    ex_funct3    = f3;
    ex_aluout    = addr;
    ex_rs2data   = rs2;
    ex_rd        = rd;
    memop = v && (re || we);
    mis   = memop && ((addr % size_of(f3)) != 0);
    al    = memop && !mis;
    k     = 0;
    done  = 1'b0;
    while (!done) begin
      ack  = al && (k == ackd);
      abrt = al && !ack && (k == TO - 1);
      stl  = al && !ack && !abrt;
      dm_ack   = ack;
      dm_rdata = ack ? rdat : $urandom;
      @(negedge clk);
      chk("dm_req", dm_req, al);
      chk("mem_stall", mem_stall, stl);
      if (al) begin
        chk("dm_addr", dm_addr, addr & ~32'h3);
        chk("dm_web", dm_web, we ? ref_web(f3, addr) : 4'h0);
        if (we) chk("dm_wdata", dm_wdata, ref_wdata(f3, rs2));
      end
      @(posedge clk);
      #1;
      if (mis)  exp_mis = 1'b1;
      if (abrt) exp_to  = 1'b1;
      if (stl) begin
        chk("bubble_valid", wb_valid, 0);
        chk("bubble_ctrl", wb_ctrl, 0);
      end else begin
        done = 1'b1;
        chk("wb_valid", wb_valid, v);
        chk("wb_ctrl", wb_ctrl,
            {wb[1], wb[0] & !(mis || abrt)});
        chk("wb_aluout", wb_aluout, addr);
        chk("wb_rd", wb_rd, rd);
        chk("wb_memout", wb_memout,
            (al && re && ack) ? ref_load(f3, addr, rdat) : 0);
        chk("err_misalign", err_misalign, exp_mis);
        chk("err_timeout", err_timeout, exp_to);
      end
      k++;
      if (!done && k > TO + 4) begin
        chk("op_cycle_bound", 0, 1);
        done = 1'b1;
      end
    end
    dm_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ldf [5];
    int r, ad;
    logic [31:0] adr;
    logic [2:0] f3;
    ldf[0] = F3_LB; ldf[1] = F3_LH; ldf[2] = F3_LW;
    ldf[3] = F3_LBU; ldf[4] = F3_LHU;

    rst = 1'b1;
    ex_valid = 1'b1; ex_wb = 2'b11;
    ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = F3_LW; ex_aluout = 32'h100;
    ex_rs2data = '0; ex_rd = 5'd1;
    dm_rdata = '0; dm_ack = 1'b0;
    #12;
    chk("rst_dm_req", dm_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_ctrl", wb_ctrl, 0);
    chk("rst_wb_memout", wb_memout, 0);
    chk("rst_wb_aluout", wb_aluout, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_err_mis", err_misalign, 0);
    chk("rst_err_to", err_timeout, 0);
    ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sync();

    // ALU op
    do_op(1, 2'b01, 0, 0, F3_LW, 32'h1234, 0, 5'd5, 0, 0);
    // LB / LBU at 0x103 with 3 wait cycles
    do_op(1, 2'b11, 1, 0, F3_LB, 32'h103, 0, 5'd6,
          32'h80FFFFFF, 3);
    chk("lb_value", wb_memout, 32'hFFFFFF80);
    do_op(1, 2'b11, 1, 0, F3_LBU, 32'h103, 0, 5'd7,
          32'h80FFFFFF, 3);
    chk("lbu_value", wb_memout, 32'h00000080);
    // SH zero-wait
    do_op(1, 2'b00, 0, 1, F3_SH, 32'h202, 32'h0000BEEF,
          5'd0, 0, 0);
    // misaligned SW
    do_op(1, 2'b01, 0, 1, F3_SW, 32'h301, 32'h55,
          5'd3, 0, 0);
    // load that is never acked
    do_op(1, 2'b11, 1, 0, F3_LW, 32'h400, 0, 5'd8, 0, -1);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("to_req_released", dm_req, 0);
    chk("to_stall_released", mem_stall, 0);
    sync();
    // ack coincides with terminal count
    do_op(1, 2'b11, 1, 0, F3_LH, 32'h502, 0, 5'd9,
          32'h8001_7FFE, TO - 1);

    // reset during WAIT
    ex_valid = 1'b1; ex_wb = 2'b11;
    ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = F3_LW; ex_aluout = 32'h600;
    ex_rd = 5'd10; dm_ack = 1'b0;
    sync();
    sync();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_dm_req", dm_req, 0);
    chk("midrst_stall", mem_stall, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_wb_ctrl", wb_ctrl, 0);
    chk("midrst_wb_memout", wb_memout, 0);
    chk("midrst_wb_aluout", wb_aluout, 0);
    chk("midrst_wb_rd", wb_rd, 0);
    chk("midrst_err_to", err_timeout, 0);
    exp_mis = 1'b0;
    exp_to  = 1'b0;
    ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sync();
    do_op(1, 2'b11, 1, 0, F3_LW, 32'h700, 0, 5'd11,
          32'hCAFEF00D, 1);

    for (int i = 0; i < 40; i++) begin
      r   = $urandom_range(0, 8);
      adr = $urandom;
      if ($urandom_range(0, 1) == 0) adr[1:0] = 2'b00;
      ad  = ($urandom_range(0, 14) == 0) ? -1
                                          : $urandom_range(0, 3);
      if (r < 3) begin
        do_op($urandom_range(0, 1), 2'($urandom), 0, 0,
              3'($urandom), adr, $urandom, 5'($urandom),
              0, 0);
      end else if (r < 6) begin
        f3 = ldf[$urandom_range(0, 4)];
        do_op(1, 2'($urandom), 1, 0, f3, adr, 0,
              5'($urandom), $urandom, ad);
      end else begin
        f3 = 3'($urandom_range(0, 2));
        do_op(1, 2'($urandom), 0, 1, f3, adr, $urandom,
              5'($urandom), 0, ad);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
